// File: rtl/audio_sample_packet_builder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audio_sample_packet_builder_if: sample-in and packet-out handshake bundle  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface audio_sample_packet_builder_if #(
  parameter int AUDIO_BIT_WIDTH = 24
);
  logic [AUDIO_BIT_WIDTH-1:0] audio_l;
  logic [AUDIO_BIT_WIDTH-1:0] audio_r;
  logic                       audio_valid;
  logic                       audio_ready;
  logic [191:0]               channel_status;
  logic                       packet_valid;
  logic                       packet_ready;
  logic [23:0]                header;
  logic [55:0]                sub0;
  logic [55:0]                sub1;
  logic [55:0]                sub2;
  logic [55:0]                sub3;

  // master: the packet builder itself
  modport master (
    input  audio_l, audio_r, audio_valid, channel_status, packet_ready,
    output audio_ready, packet_valid, header, sub0, sub1, sub2, sub3
  );

  modport slave (
    output audio_l, audio_r, audio_valid, channel_status, packet_ready,
    input  audio_ready, packet_valid, header, sub0, sub1, sub2, sub3
  );
endinterface
`default_nettype wire

// File: rtl/audio_sample_packet_builder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | audio_sample_packet_builder: HDMI audio sample packet (type 0x02, layout 0)|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module audio_sample_packet_builder #(
  parameter int AUDIO_BIT_WIDTH    = 24,
  parameter int SAMPLES_PER_PACKET = 4
) (
  input  wire logic                     clk_pixel,
  input  wire logic                     reset,
  audio_sample_packet_builder_if.master bus
);
  localparam logic [2:0] c_SPP  = 3'(SAMPLES_PER_PACKET);
  localparam logic [2:0] c_LAST = 3'(SAMPLES_PER_PACKET - 1);

  logic [2:0]  r_count;
  logic [7:0]  r_fc;
  logic        r_pvalid;
  logic [23:0] r_header;
  logic [55:0] r_sub [4];

  logic [23:0] w_l;
  logic [23:0] w_r;
  logic        w_c;
  logic        w_accept;
  logic        w_out_free;
  logic        w_load;
  logic [55:0] w_sub [4];
  logic [3:0]  w_b;
  logic [3:0]  w_present;

  // Byte 6 carries {P_R, C_R, U_R, V_R, P_L, C_L, U_L, V_L} with V = U = 0.
  function automatic logic [55:0] f_sub(input logic [23:0] l, input logic [23:0] r,
                                        input logic c);
    f_sub = {(^r) ^ c, c, 2'b00, (^l) ^ c, c, 2'b00, r, l};
  endfunction

  generate
    if (AUDIO_BIT_WIDTH == 24) begin : g_full_width
      assign w_l = bus.audio_l;
      assign w_r = bus.audio_r;
    end else begin : g_justify
      assign w_l = {bus.audio_l, {(24 - AUDIO_BIT_WIDTH){1'b0}}};
      assign w_r = {bus.audio_r, {(24 - AUDIO_BIT_WIDTH){1'b0}}};
    end
  endgenerate

  assign bus.audio_ready = (r_count != c_SPP);
  assign w_accept        = bus.audio_valid && bus.audio_ready;
  assign w_c             = bus.channel_status[r_fc];
  assign w_out_free      = !r_pvalid || bus.packet_ready;
  assign w_load          = w_out_free &&
                           ((w_accept && (r_count == c_LAST)) || (r_count == c_SPP));

  generate
    for (genvar i = 0; i < 4; i++) begin : g_slot
      if (i < SAMPLES_PER_PACKET) begin : g_used
        logic [23:0] r_sl;
        logic [23:0] r_sr;
        logic        r_sc;
        logic        r_sb;
        logic        w_here;

        assign w_here = w_accept && (r_count == 3'(i));

        always_ff @(posedge clk_pixel or posedge reset) begin
          if (reset) begin
            r_sl <= '0;
            r_sr <= '0;
            r_sc <= 1'b0;
            r_sb <= 1'b0;
          end else if (w_here) begin
            r_sl <= w_l;
            r_sr <= w_r;
            r_sc <= w_c;
            r_sb <= (r_fc == 8'd0);
          end
        end

        // The sample arriving this cycle bypasses the buffer so the final
        // accept can load the output without an extra cycle.
        assign w_sub[i]     = w_here ? f_sub(w_l, w_r, w_c) : f_sub(r_sl, r_sr, r_sc);
        assign w_b[i]       = w_here ? (r_fc == 8'd0) : r_sb;
        assign w_present[i] = 1'b1;
      end else begin : g_unused
        assign w_sub[i]     = '0;
        assign w_b[i]       = 1'b0;
        assign w_present[i] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_fc     <= '0;
      r_pvalid <= 1'b0;
      r_header <= '0;
      for (int i = 0; i < 4; i++) r_sub[i] <= '0;
    end else begin
      if (w_accept) r_fc <= (r_fc == 8'd191) ? 8'd0 : r_fc + 8'd1;
      if (w_load) begin
        r_count  <= '0;
        r_pvalid <= 1'b1;
        r_header <= {w_b, 4'h0, 4'h0, w_present, 8'h02};
        for (int i = 0; i < 4; i++) r_sub[i] <= w_sub[i];
      end else begin
        if (w_accept) r_count <= (r_count == c_LAST) ? c_SPP : r_count + 3'd1;
        if (bus.packet_ready) r_pvalid <= 1'b0;
      end
    end
  end

  assign bus.packet_valid = r_pvalid;
  assign bus.header       = r_header;
  assign bus.sub0         = r_sub[0];
  assign bus.sub1         = r_sub[1];
  assign bus.sub2         = r_sub[2];
  assign bus.sub3         = r_sub[3];
endmodule
`default_nettype wire

// File: tb/tb_audio_sample_packet_builder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_audio_sample_packet_builder: directed self-checking bench               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_audio_sample_packet_builder;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  audio_sample_packet_builder_if #(.AUDIO_BIT_WIDTH(24)) ifm  ();
  audio_sample_packet_builder_if #(.AUDIO_BIT_WIDTH(16)) if16 ();
  audio_sample_packet_builder_if #(.AUDIO_BIT_WIDTH(24)) if1  ();

  audio_sample_packet_builder #(.AUDIO_BIT_WIDTH(24), .SAMPLES_PER_PACKET(4)) dut_m (
    .clk_pixel(clk), .reset(rst), .bus(ifm.master));
  audio_sample_packet_builder #(.AUDIO_BIT_WIDTH(16), .SAMPLES_PER_PACKET(4)) dut_16 (
    .clk_pixel(clk), .reset(rst), .bus(if16.master));
  audio_sample_packet_builder #(.AUDIO_BIT_WIDTH(24), .SAMPLES_PER_PACKET(1)) dut_1 (
    .clk_pixel(clk), .reset(rst), .bus(if1.master));

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        c;
    logic [23:0] hdr;
    logic [55:0] sub;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one sample pair to the main instance and return just after it is taken.
  task automatic push_m(input logic [23:0] l, input logic [23:0] r);
    int t;
    ifm.audio_l     = l;
    ifm.audio_r     = r;
    ifm.audio_valid = 1'b1;
    t = 0;
    while (!ifm.audio_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_before_accept", 64'(ifm.audio_ready), 64'd1);
    @(posedge clk); #1;
    ifm.audio_valid = 1'b0;
  endtask

  task automatic chk_pkt_m(input string name, input logic [23:0] hdr, input logic [55:0] s);
    chk({name, "_valid"}, 64'(ifm.packet_valid), 64'd1);
    chk({name, "_header"}, 64'(ifm.header), 64'(hdr));
    chk({name, "_sub0"}, 64'(ifm.sub0), 64'(s));
    chk({name, "_sub1"}, 64'(ifm.sub1), 64'(s));
    chk({name, "_sub2"}, 64'(ifm.sub2), 64'(s));
    chk({name, "_sub3"}, 64'(ifm.sub3), 64'(s));
  endtask

  initial begin
    vecs[0] = '{24'h000001, 24'h800000, 1'b0, 24'h100F02, 56'h88_800000_000001};
    vecs[1] = '{24'h000000, 24'h000000, 1'b0, 24'h000F02, 56'h00_000000_000000};
    vecs[2] = '{24'hFFFFFF, 24'h000003, 1'b1, 24'h000F02, 56'hCC_000003_FFFFFF};
    vecs[3] = '{24'h123456, 24'hABCDEF, 1'b0, 24'h000F02, 56'h88_ABCDEF_123456};
    vecs[4] = '{24'h800000, 24'h7FFFFF, 1'b1, 24'h000F02, 56'h44_7FFFFF_800000};
    vecs[5] = '{24'h0F0F0F, 24'h000000, 1'b1, 24'h000F02, 56'hCC_000000_0F0F0F};

    ifm.audio_l = '0;  ifm.audio_r = '0;  ifm.audio_valid = 1'b0;
    ifm.channel_status = '0;  ifm.packet_ready = 1'b0;
    if16.audio_l = '0; if16.audio_r = '0; if16.audio_valid = 1'b0;
    if16.channel_status = '0; if16.packet_ready = 1'b0;
    if1.audio_l = '0;  if1.audio_r = '0;  if1.audio_valid = 1'b0;
    if1.channel_status = '0;  if1.packet_ready = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(ifm.packet_valid), 64'd0);
    chk("rst_m_ready", 64'(ifm.audio_ready), 64'd1);
    chk("rst_m_header", 64'(ifm.header), 64'd0);
    chk("rst_m_sub0", 64'(ifm.sub0), 64'd0);
    chk("rst_16_valid", 64'(if16.packet_valid), 64'd0);
    chk("rst_16_ready", 64'(if16.audio_ready), 64'd1);
    chk("rst_1_valid", 64'(if1.packet_valid), 64'd0);
    chk("rst_1_ready", 64'(if1.audio_ready), 64'd1);
    rst = 1'b0;

    // 16-bit samples are left-justified into the 24-bit fields.
    if16.packet_ready = 1'b1;
    if16.audio_l      = 16'hFFFF;
    if16.audio_r      = 16'h0001;
    if16.audio_valid  = 1'b1;
    repeat (4) begin
      chk("w16_ready", 64'(if16.audio_ready), 64'd1);
      @(posedge clk); #1;
    end
    if16.audio_valid = 1'b0;
    chk("w16_valid", 64'(if16.packet_valid), 64'd1);
    chk("w16_header", 64'(if16.header), 64'h100F02);
    chk("w16_sub0", 64'(if16.sub0), 64'h80_000100_FFFF00);
    chk("w16_sub3", 64'(if16.sub3), 64'h80_000100_FFFF00);

    ifm.packet_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      ifm.channel_status = vecs[v].c ? '1 : '0;
      repeat (4) push_m(vecs[v].l, vecs[v].r);
      chk_pkt_m($sformatf("vec%0d", v), vecs[v].hdr, vecs[v].sub);
    end
    @(posedge clk); #1;
    chk("consume_clears_valid", 64'(ifm.packet_valid), 64'd0);

    // Back-pressure: second packet parks in the buffer while the first is held.
    ifm.channel_status = '0;
    ifm.packet_ready   = 1'b0;
    repeat (4) push_m(24'h000011, 24'h000022);
    chk_pkt_m("bp_first", 24'h000F02, 56'h00_000022_000011);
    repeat (4) push_m(24'h000044, 24'h000055);
    chk("bp_full_ready", 64'(ifm.audio_ready), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_hold_ready", 64'(ifm.audio_ready), 64'd0);
      chk("bp_hold_valid", 64'(ifm.packet_valid), 64'd1);
      chk("bp_hold_sub0", 64'(ifm.sub0), 64'h00_000022_000011);
    end
    ifm.packet_ready = 1'b1;
    @(posedge clk); #1;
    chk_pkt_m("bp_second", 24'h000F02, 56'h00_000055_000044);
    chk("bp_ready_again", 64'(ifm.audio_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_drained", 64'(ifm.packet_valid), 64'd0);

    // Reset in the middle of a packet discards the partial samples.
    push_m(24'h00ABCD, 24'h000123);
    push_m(24'h00ABCD, 24'h000123);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 64'(ifm.packet_valid), 64'd0);
    chk("midrst_header", 64'(ifm.header), 64'd0);
    chk("midrst_sub0", 64'(ifm.sub0), 64'd0);
    chk("midrst_sub2", 64'(ifm.sub2), 64'd0);
    chk("midrst_ready", 64'(ifm.audio_ready), 64'd1);

    // 49 packets cross the 192-frame block boundary.
    ifm.channel_status = 192'd1;
    for (int p = 0; p < 49; p++) begin
      repeat (4) push_m(24'h000000, 24'h000000);
      chk($sformatf("wrap%0d_header", p), 64'(ifm.header),
          (p == 0 || p == 48) ? 64'h100F02 : 64'h000F02);
      chk($sformatf("wrap%0d_sub1", p), 64'(ifm.sub1), 64'd0);
      if (p == 0 || p == 48)
        chk($sformatf("wrap%0d_sub0", p), 64'(ifm.sub0), 64'hCC_000000_000000);
    end

    // One sample per packet, one packet per cycle.
    if1.packet_ready = 1'b1;
    if1.audio_l      = 24'd0;
    if1.audio_valid  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      chk("spp1_ready", 64'(if1.audio_ready), 64'd1);
      chk("spp1_valid", 64'(if1.packet_valid), 64'd1);
      chk($sformatf("spp1_header_%0d", k), 64'(if1.header),
          (k % 192 == 0) ? 64'h100102 : 64'h000102);
      chk("spp1_sub0_left", 64'(if1.sub0[23:0]), 64'(k));
      chk("spp1_sub1", 64'(if1.sub1), 64'd0);
      chk("spp1_sub3", 64'(if1.sub3), 64'd0);
      if1.audio_l = 24'(k + 1);
    end
    if1.audio_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
